// File: rtl/sram_arbiter.sv
// Two-master arbiter for a 1R+1W sram: independent round-robin read and write
// arbitration, with read data steered back to its owner one cycle after grant.
module sram_arbiter #(
    parameter int unsigned AWIDTH = 16,
    parameter int unsigned DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [AWIDTH-1:0] m0_addr,
    input  logic [DWIDTH-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DWIDTH-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [AWIDTH-1:0] m1_addr,
    input  logic [DWIDTH-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DWIDTH-1:0] m1_rdata,
    output logic [AWIDTH-1:0] sram_waddr,
    output logic [DWIDTH-1:0] sram_wdata,
    output logic              sram_we,
    output logic [AWIDTH-1:0] sram_raddr,
    output logic              sram_re,
    input  logic [DWIDTH-1:0] sram_rdata
);

    logic rd_last_q, rd_last_d;
    logic wr_last_q, wr_last_d;
    logic rd_pend_q, rd_pend_d;
    logic rd_owner_q, rd_owner_d;

    logic rd_req0, rd_req1, wr_req0, wr_req1;
    logic rd_gnt0, rd_gnt1, wr_gnt0, wr_gnt1;

    // Grants are held off while in reset so no sram access leaks out.
    always_comb begin
        rd_req0 = rst_n & m0_req & ~m0_we;
        rd_req1 = rst_n & m1_req & ~m1_we;
        wr_req0 = rst_n & m0_req &  m0_we;
        wr_req1 = rst_n & m1_req &  m1_we;

        rd_gnt0 = rd_req0 & (~rd_req1 |  rd_last_q);
        rd_gnt1 = rd_req1 & (~rd_req0 | ~rd_last_q);
        wr_gnt0 = wr_req0 & (~wr_req1 |  wr_last_q);
        wr_gnt1 = wr_req1 & (~wr_req0 | ~wr_last_q);
    end

    always_comb begin
        rd_last_d  = rd_last_q;
        wr_last_d  = wr_last_q;
        rd_pend_d  = 1'b0;
        rd_owner_d = rd_owner_q;

        m0_gnt     = rd_gnt0 | wr_gnt0;
        m1_gnt     = rd_gnt1 | wr_gnt1;

        sram_re    = rd_gnt0 | rd_gnt1;
        sram_raddr = '0;
        sram_we    = wr_gnt0 | wr_gnt1;
        sram_waddr = '0;
        sram_wdata = '0;

        if (rd_gnt0) begin
            sram_raddr = m0_addr;
            rd_last_d  = 1'b0;
            rd_owner_d = 1'b0;
        end else if (rd_gnt1) begin
            sram_raddr = m1_addr;
            rd_last_d  = 1'b1;
            rd_owner_d = 1'b1;
        end
        rd_pend_d = sram_re;

        if (wr_gnt0) begin
            sram_waddr = m0_addr;
            sram_wdata = m0_wdata;
            wr_last_d  = 1'b0;
        end else if (wr_gnt1) begin
            sram_waddr = m1_addr;
            sram_wdata = m1_wdata;
            wr_last_d  = 1'b1;
        end
    end

    // Pointers reset to master 1 so master 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_last_q  <= 1'b1;
            wr_last_q  <= 1'b1;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            rd_last_q  <= rd_last_d;
            wr_last_q  <= wr_last_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        m0_rvalid = rd_pend_q & ~rd_owner_q;
        m1_rvalid = rd_pend_q &  rd_owner_q;
        m0_rdata  = m0_rvalid ? sram_rdata : '0;
        m1_rdata  = m1_rvalid ? sram_rdata : '0;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed table-driven bench for sram_arbiter with a behavioural 4Kx16
// read-before-write sram attached to the arbiter's sram port.
module tb_sram_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int OPI = 0;
    localparam int OPR = 1;
    localparam int OPW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] sram_waddr, sram_raddr;
    logic [DW-1:0] sram_wdata, sram_rdata;
    logic          sram_we, sram_re;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem [0:4095];

    always #5 clk = ~clk;

    sram_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .sram_waddr(sram_waddr), .sram_wdata(sram_wdata), .sram_we(sram_we),
        .sram_raddr(sram_raddr), .sram_re(sram_re), .sram_rdata(sram_rdata)
    );

    // Registered read of old contents; write lands at the same edge.
    always @(posedge clk) begin
        if (sram_re) sram_rdata <= mem[sram_raddr[11:0]];
        if (sram_we) mem[sram_waddr[11:0]] <= sram_wdata;
    end

    typedef struct {
        int          op0;
        logic [15:0] a0, d0;
        int          op1;
        logic [15:0] a1, d1;
        logic        g0, g1, rv0, rv1;
        logic [15:0] rd0, rd1;
        logic [1:0]  rewe;
        logic [15:0] raddr, waddr, wdata;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(int op0, logic [15:0] a0, logic [15:0] d0,
                                int op1, logic [15:0] a1, logic [15:0] d1,
                                logic g0, logic g1,
                                logic rv0, logic [15:0] rd0,
                                logic rv1, logic [15:0] rd1,
                                logic [1:0] rewe, logic [15:0] raddr,
                                logic [15:0] waddr, logic [15:0] wdata);
        vec_t v;
        v.op0 = op0; v.a0 = a0; v.d0 = d0;
        v.op1 = op1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rd0 = rd0; v.rv1 = rv1; v.rd1 = rd1;
        v.rewe = rewe; v.raddr = raddr; v.waddr = waddr; v.wdata = wdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int op0, input logic [15:0] a0, input logic [15:0] d0,
                         input int op1, input logic [15:0] a1, input logic [15:0] d1);
        m0_req = (op0 != OPI); m0_we = (op0 == OPW); m0_addr = a0; m0_wdata = d0;
        m1_req = (op1 != OPI); m1_we = (op1 == OPW); m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic chk_vec(input int idx, input vec_t v);
        string s;
        s = $sformatf("v%0d", idx);
        chk({s, ".m0_gnt"},    32'(m0_gnt),     32'(v.g0));
        chk({s, ".m1_gnt"},    32'(m1_gnt),     32'(v.g1));
        chk({s, ".m0_rvalid"}, 32'(m0_rvalid),  32'(v.rv0));
        chk({s, ".m1_rvalid"}, 32'(m1_rvalid),  32'(v.rv1));
        chk({s, ".m0_rdata"},  32'(m0_rdata),   32'(v.rd0));
        chk({s, ".m1_rdata"},  32'(m1_rdata),   32'(v.rd1));
        chk({s, ".re_we"},     32'({sram_re, sram_we}), 32'(v.rewe));
        chk({s, ".raddr"},     32'(sram_raddr), 32'(v.raddr));
        chk({s, ".waddr"},     32'(sram_waddr), 32'(v.waddr));
        chk({s, ".wdata"},     32'(sram_wdata), 32'(v.wdata));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        sram_rdata = '0;

        // Single write then read-back
        tv.push_back(mk(OPW,16'h005,16'h1234, OPI,0,0, 1,0, 0,0, 0,0, 2'b01, 0,16'h005,16'h1234));
        tv.push_back(mk(OPR,16'h005,0, OPI,0,0,           1,0, 0,0, 0,0, 2'b10, 16'h005,0,0));
        tv.push_back(mk(OPI,0,0, OPI,0,0,                 0,0, 1,16'h1234, 0,0, 2'b00, 0,0,0));
        // Preload and read contention 0,1,0,1
        tv.push_back(mk(OPW,16'h010,16'hAAAA, OPI,0,0,    1,0, 0,0, 0,0, 2'b01, 0,16'h010,16'hAAAA));
        tv.push_back(mk(OPI,0,0, OPW,16'h020,16'hBBBB,    0,1, 0,0, 0,0, 2'b01, 0,16'h020,16'hBBBB));
        tv.push_back(mk(OPI,0,0, OPR,16'h020,0,           0,1, 0,0, 0,0, 2'b10, 16'h020,0,0));
        tv.push_back(mk(OPR,16'h010,0, OPR,16'h020,0,     1,0, 0,0, 1,16'hBBBB, 2'b10, 16'h010,0,0));
        tv.push_back(mk(OPR,16'h010,0, OPR,16'h020,0,     0,1, 1,16'hAAAA, 0,0, 2'b10, 16'h020,0,0));
        tv.push_back(mk(OPR,16'h010,0, OPR,16'h020,0,     1,0, 0,0, 1,16'hBBBB, 2'b10, 16'h010,0,0));
        tv.push_back(mk(OPR,16'h010,0, OPR,16'h020,0,     0,1, 1,16'hAAAA, 0,0, 2'b10, 16'h020,0,0));
        // Parallel read and write
        tv.push_back(mk(OPR,16'h030,0, OPW,16'h040,16'h5555, 1,1, 0,0, 1,16'hBBBB, 2'b11, 16'h030,16'h040,16'h5555));
        tv.push_back(mk(OPI,0,0, OPI,0,0,                 0,0, 1,16'h0000, 0,0, 2'b00, 0,0,0));
        tv.push_back(mk(OPI,0,0, OPR,16'h040,0,           0,1, 0,0, 0,0, 2'b10, 16'h040,0,0));
        tv.push_back(mk(OPI,0,0, OPI,0,0,                 0,0, 0,0, 1,16'h5555, 2'b00, 0,0,0));
        // Same-address read/write collision: read sees old data
        tv.push_back(mk(OPW,16'h050,16'h1111, OPI,0,0,    1,0, 0,0, 0,0, 2'b01, 0,16'h050,16'h1111));
        tv.push_back(mk(OPR,16'h050,0, OPW,16'h050,16'h2222, 1,1, 0,0, 0,0, 2'b11, 16'h050,16'h050,16'h2222));
        tv.push_back(mk(OPI,0,0, OPR,16'h050,0,           0,1, 1,16'h1111, 0,0, 2'b10, 16'h050,0,0));
        tv.push_back(mk(OPI,0,0, OPI,0,0,                 0,0, 0,0, 1,16'h2222, 2'b00, 0,0,0));
        // Write contention, six cycles, data advances only after a grant
        tv.push_back(mk(OPW,16'h060,16'h0001, OPW,16'h061,16'h0101, 1,0, 0,0, 0,0, 2'b01, 0,16'h060,16'h0001));
        tv.push_back(mk(OPW,16'h060,16'h0002, OPW,16'h061,16'h0101, 0,1, 0,0, 0,0, 2'b01, 0,16'h061,16'h0101));
        tv.push_back(mk(OPW,16'h060,16'h0002, OPW,16'h061,16'h0102, 1,0, 0,0, 0,0, 2'b01, 0,16'h060,16'h0002));
        tv.push_back(mk(OPW,16'h060,16'h0003, OPW,16'h061,16'h0102, 0,1, 0,0, 0,0, 2'b01, 0,16'h061,16'h0102));
        tv.push_back(mk(OPW,16'h060,16'h0003, OPW,16'h061,16'h0103, 1,0, 0,0, 0,0, 2'b01, 0,16'h060,16'h0003));
        tv.push_back(mk(OPW,16'h060,16'h0004, OPW,16'h061,16'h0103, 0,1, 0,0, 0,0, 2'b01, 0,16'h061,16'h0103));
        tv.push_back(mk(OPR,16'h060,0, OPR,16'h061,0,     1,0, 0,0, 0,0, 2'b10, 16'h060,0,0));
        tv.push_back(mk(OPI,0,0, OPR,16'h061,0,           0,1, 1,16'h0003, 0,0, 2'b10, 16'h061,0,0));
        tv.push_back(mk(OPI,0,0, OPI,0,0,                 0,0, 0,0, 1,16'h0103, 2'b00, 0,0,0));

        // Outputs stay quiet while held in reset, even with requests up
        rst_n = 1'b0;
        drive(OPR, 16'h010, 0, OPW, 16'h020, 16'h9999);
        #4;
        chk("rst.m0_gnt", 32'(m0_gnt), 0);
        chk("rst.m1_gnt", 32'(m1_gnt), 0);
        chk("rst.re_we", 32'({sram_re, sram_we}), 0);
        chk("rst.raddr", 32'(sram_raddr), 0);
        chk("rst.rvalid", 32'({m0_rvalid, m1_rvalid}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(OPI, 0, 0, OPI, 0, 0);

        foreach (tv[i]) begin
            @(posedge clk);
            #1 drive(tv[i].op0, tv[i].a0, tv[i].d0, tv[i].op1, tv[i].a1, tv[i].d1);
            #3 chk_vec(i, tv[i]);
        end

        // Reset lands between an m1 read grant and its return
        @(posedge clk);
        #1 drive(OPI, 0, 0, OPR, 16'h020, 0);
        #3 chk("mid.m1_gnt", 32'(m1_gnt), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.rst_gnt", 32'({m0_gnt, m1_gnt}), 0);
        chk("mid.rst_re", 32'(sram_re), 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #4;
            chk("mid.rst_m1_rvalid", 32'(m1_rvalid), 0);
            chk("mid.rst_out", 32'({m0_gnt, m1_gnt, sram_re, sram_we}), 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(OPR, 16'h010, 0, OPR, 16'h020, 0);
        #3;
        chk("mid.post_g0", 32'(m0_gnt), 1);
        chk("mid.post_g1", 32'(m1_gnt), 0);
        chk("mid.post_m1_rvalid", 32'(m1_rvalid), 0);
        chk("mid.post_raddr", 32'(sram_raddr), 32'h010);
        @(posedge clk);
        #1 drive(OPI, 0, 0, OPI, 0, 0);
        #3;
        chk("mid.ret_m0_rdata", 32'({m0_rvalid, m0_rdata}), 32'h1AAAA);
        chk("mid.ret_m1_rvalid", 32'(m1_rvalid), 0);

        // Pointers left on master 0 must be restored to favour master 0
        @(posedge clk);
        #1 drive(OPR, 16'h010, 0, OPI, 0, 0);
        @(posedge clk);
        #1 drive(OPW, 16'h070, 16'h7777, OPI, 0, 0);
        #3 chk("ptr.pre_m0_rdata", 32'({m0_rvalid, m0_rdata}), 32'h1AAAA);
        @(posedge clk);
        #1 rst_n = 1'b0;
        drive(OPI, 0, 0, OPI, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(OPR, 16'h010, 0, OPR, 16'h020, 0);
        #3 chk("ptr.rd_gnt", 32'({m0_gnt, m1_gnt}), 32'b10);
        @(posedge clk);
        #1 drive(OPW, 16'h070, 16'h0070, OPW, 16'h071, 16'h0071);
        #3;
        chk("ptr.wr_gnt", 32'({m0_gnt, m1_gnt}), 32'b10);
        chk("ptr.waddr", 32'(sram_waddr), 32'h070);
        chk("ptr.rv_after_rd", 32'({m0_rvalid, m0_rdata}), 32'h1AAAA);
        @(posedge clk);
        #1 drive(OPI, 0, 0, OPI, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
